// File: rtl/core_rx.sv
// ---------------------------------------------------------------------------
// core_rx -- serial receiver for the hit-counter core TX line.
//
// Recovers framed 4-bit counts from the line and presents them in parallel
// with a one-cycle valid strobe. Frame: start(0), D0..D3 LSB first,
// [even parity], stop(1); every bit lasts OVS clocks.
//
// Optional feature macro: PARITY_EN
//   defined   -> parity bit after D3, even parity checked, par_err reported
//   undefined -> 6-bit frame, par_err tied 0
//
// Parameters
//   OVS        clocks per serial bit (even, >= 4)
// Ports
//   clk        in   system clock, rising edge
//   clr        in   synchronous active-high reset
//   rx         in   serial line, idles high, asynchronous to clk
//   nom        out  last correctly received count
//   nom_valid  out  one-cycle pulse, nom updated
//   bit_idx    out  data bit being received (0 outside DATA)
//   le         out  one-hot of bit_idx in DATA, 0 otherwise
//   busy       out  high in every state except IDLE
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   par_err    out  one-cycle pulse, parity mismatch
//
// Handshake: nom_valid is a strobe with no ready; nom is stable from the
// cycle nom_valid is high until the next good frame.
// ---------------------------------------------------------------------------
module core_rx #(
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    output logic [3:0] nom,
    output logic       nom_valid,
    output logic [1:0] bit_idx,
    output logic [3:0] le,
    output logic       busy,
    output logic       frame_err,
    output logic       par_err
);

    localparam int CW = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            rx_m_q, rx_m_d;
    logic            rx_s_q, rx_s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      nbit_q, nbit_d;
    logic [3:0]      shift_q, shift_d;
    logic [3:0]      nom_q, nom_d;
    logic            nom_valid_q, nom_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            par_err_q, par_err_d;
    logic            par_ok;
`ifdef PARITY_EN
    logic            par_bit_q, par_bit_d;
`endif

`ifdef PARITY_EN
    assign par_ok = ~(^{shift_q, par_bit_q});
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        rx_m_d      = rx;
        rx_s_d      = rx_m_q;
        cnt_d       = cnt_q;
        nbit_d      = nbit_q;
        shift_d     = shift_q;
        nom_d       = nom_q;
        nom_valid_d = 1'b0;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
`ifdef PARITY_EN
        par_bit_d   = par_bit_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the line mid start bit; a high here was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d  = '0;
                    nbit_d = 2'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    // Line is LSB first, so shifting in at the MSB leaves D0 at bit 0.
                    shift_d = {rx_s_q, shift_q[3:1]};
                    cnt_d   = '0;
                    nbit_d  = nbit_q + 1'b1;
                    if (nbit_q == 2'd3) begin
`ifdef PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                if (cnt_q == CNT_LAST) begin
                    par_bit_d = rx_s_q;
                    cnt_d     = '0;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = ~par_ok;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        if (par_ok) begin
                            nom_d       = shift_q;
                            nom_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // Held-low line: stay here so only one frame_err is reported.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            nbit_q      <= 2'd0;
            shift_q     <= 4'd0;
            nom_q       <= 4'd0;
            nom_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
`ifdef PARITY_EN
            par_bit_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_m_q      <= rx_m_d;
            rx_s_q      <= rx_s_d;
            cnt_q       <= cnt_d;
            nbit_q      <= nbit_d;
            shift_q     <= shift_d;
            nom_q       <= nom_d;
            nom_valid_q <= nom_valid_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
`ifdef PARITY_EN
            par_bit_q   <= par_bit_d;
`endif
        end
    end

    assign nom       = nom_q;
    assign nom_valid = nom_valid_q;
    assign frame_err = frame_err_q;
    assign par_err   = par_err_q;
    assign busy      = (state_q != S_IDLE);
    assign bit_idx   = (state_q == S_DATA) ? nbit_q : 2'd0;
    assign le        = (state_q == S_DATA) ? (4'b0001 << nbit_q) : 4'b0000;

endmodule

// File: tb/tb_core_rx.sv
// ---------------------------------------------------------------------------
// tb_core_rx -- directed bench for core_rx with OVS=4.
// Inputs are driven 1 time unit after each rising edge; outputs are
// observed on the falling edge by a monitor and right after each step.
// ---------------------------------------------------------------------------
module tb_core_rx;

    localparam int OVS = 4;
`ifdef PARITY_EN
    localparam int LAT = 29;
`else
    localparam int LAT = 25;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rx  = 1'b1;
    logic [3:0] nom;
    logic       nom_valid;
    logic [1:0] bit_idx;
    logic [3:0] le;
    logic       busy;
    logic       frame_err;
    logic       par_err;

    always #5 clk = ~clk;

    core_rx #(.OVS(OVS)) dut (
        .clk       (clk),
        .clr       (clr),
        .rx        (rx),
        .nom       (nom),
        .nom_valid (nom_valid),
        .bit_idx   (bit_idx),
        .le        (le),
        .busy      (busy),
        .frame_err (frame_err),
        .par_err   (par_err)
    );

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    int         ecnt  = 0;
    int         nv_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         last_nv_edge = 0;
    logic [3:0] exp_q[$];
    int         le_q[$];
    int         bi_q[$];
    logic [3:0] prev_le = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: counts strobes, logs le/bit_idx steps, checks every nom_valid
    // against the expected queue.
    always @(negedge clk) begin
        if (le !== prev_le) begin
            if (le != 4'd0) begin
                le_q.push_back(int'(le));
                bi_q.push_back(int'(bit_idx));
            end
            prev_le = le;
        end
        if (nom_valid === 1'b1) begin
            nv_cnt++;
            last_nv_edge = ecnt;
            check("nom_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("nom_value", 32'(nom), 32'(exp_q.pop_front()));
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (par_err === 1'b1) pe_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic step(input logic b);
        rx = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        repeat (OVS) step(b);
    endtask

    task automatic send_head(input logic [3:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
`ifdef PARITY_EN
        send_bit(^d);
`endif
    endtask

    task automatic send_frame(input logic [3:0] d, input logic stop_b);
        send_head(d);
        send_bit(stop_b);
    endtask

    // ---------------- directed sequence ----------------
    int e0, nv0, fe0, pe0;

    initial begin
        // 1. reset
        clr = 1'b1;
        repeat (3) step(1'b1);
        check("rst_nom", 32'(nom), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_nom_valid", 32'(nom_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        check("rst_le", 32'(le), 32'h0);
        check("rst_bit_idx", 32'(bit_idx), 32'h0);
        clr = 1'b0;
        repeat (3) step(1'b1);

        // 2. single frame 0x5: latency, le stepping
        le_q.delete();
        bi_q.delete();
        nv0 = nv_cnt;
        e0  = ecnt;
        exp_q.push_back(4'h5);
        send_frame(4'h5, 1'b1);
        repeat (4) step(1'b1);
        check("f5_pulses", 32'(nv_cnt - nv0), 32'd1);
        check("f5_latency", 32'(last_nv_edge - e0), 32'(LAT));
        check("f5_nom", 32'(nom), 32'h5);
        check("f5_le_steps", 32'(le_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < le_q.size()) begin
                check($sformatf("f5_le%0d", k), 32'(le_q[k]), 32'(1 << k));
                check($sformatf("f5_bit_idx%0d", k), 32'(bi_q[k]), 32'(k));
            end
        end

        // 3. 0x0..0xF back to back
        nv0 = nv_cnt;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        for (int d = 0; d < 16; d++) begin
            exp_q.push_back(4'(d));
            send_frame(4'(d), 1'b1);
        end
        repeat (6) step(1'b1);
        check("b2b_pulses", 32'(nv_cnt - nv0), 32'd16);
        check("b2b_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("b2b_par_err", 32'(pe_cnt - pe0), 32'd0);
        check("b2b_last_nom", 32'(nom), 32'hF);

        // 4. 0xA with low stop bit, line held low
        nv0 = nv_cnt;
        fe0 = fe_cnt;
        send_head(4'hA);
        repeat (40) step(1'b0);
        check("brk_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("brk_nom_kept", 32'(nom), 32'hF);
        check("brk_no_valid", 32'(nv_cnt - nv0), 32'd0);
        check("brk_busy_low", 32'(busy), 32'd1);
        repeat (2) step(1'b1);
        check("brk_busy_sync", 32'(busy), 32'd1);
        step(1'b1);
        check("brk_busy_idle", 32'(busy), 32'd0);

        // 5a. one-cycle glitch in IDLE
        nv0 = nv_cnt;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("gl_busy_start", 32'(busy), 32'd1);
        repeat (8) step(1'b1);
        check("gl_busy_idle", 32'(busy), 32'd0);
        check("gl_strobes", 32'((nv_cnt - nv0) + (fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
        check("gl_nom", 32'(nom), 32'hF);

        // 5b. clr in the middle of DATA
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("mid_bit_idx", 32'(bit_idx), 32'd1);
        check("mid_le", 32'(le), 32'h2);
        clr = 1'b1;
        step(1'b1);
        check("clr_nom", 32'(nom), 32'h0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_le", 32'(le), 32'h0);
        check("clr_bit_idx", 32'(bit_idx), 32'd0);
        clr = 1'b0;
        nv0 = nv_cnt;
        repeat (30) step(1'b1);
        check("clr_no_valid", 32'(nv_cnt - nv0), 32'd0);
        exp_q.push_back(4'h9);
        send_frame(4'h9, 1'b1);
        repeat (4) step(1'b1);
        check("clr_recover_nom", 32'(nom), 32'h9);

`ifdef PARITY_EN
        // 6. parity: good then bad for 0x7
        pe0 = pe_cnt;
        exp_q.push_back(4'h7);
        send_frame(4'h7, 1'b1);
        repeat (4) step(1'b1);
        check("par_good_nom", 32'(nom), 32'h7);
        check("par_good_err", 32'(pe_cnt - pe0), 32'd0);
        pe0 = pe_cnt;
        nv0 = nv_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (4) step(1'b1);
        check("par_bad_err", 32'(pe_cnt - pe0), 32'd1);
        check("par_bad_no_valid", 32'(nv_cnt - nv0), 32'd0);
        check("par_bad_nom", 32'(nom), 32'h7);
`endif

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
